// File: rtl/display_value_convert.sv
// Value-to-digit converter: hex pass-through or double-dabble BCD, start/done.
// Build option DISP_SAT_EN: saturate digits on overflow instead of blanking.
module display_value_convert #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_WIDTH-1:0]   value,
  input  logic                  hexMode,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  overflow
);

  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam int EW = (IN_WIDTH > DW) ? IN_WIDTH : DW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HEX   = 2'd1,
    SHIFT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IN_WIDTH-1:0] val_q, val_d;
  logic [DW-1:0]       scr_q, scr_d;
  logic                carry_q, carry_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;

  logic [DW-1:0]       adj;
  logic [DW-1:0]       shifted;
  logic [EW-1:0]       val_ext;
  logic                hex_ovf;
  logic                sh_ovf;
  logic                last;
  logic [DW-1:0]       sat_hex;
  logic [DW-1:0]       sat_dec;

`ifdef DISP_SAT_EN
  assign sat_hex = {DIGITS{4'hF}};
  assign sat_dec = {DIGITS{4'h9}};
`else
  assign sat_hex = '0;
  assign sat_dec = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      val_q   <= '0;
      scr_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      dig_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      scr_q   <= scr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign last = (cnt_q == CW'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = hexMode ? HEX : SHIFT;
        end
      end
      HEX: state_d = IDLE;
      SHIFT: begin
        if (last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // add-3 correction per digit, then one shift step of {scratch, value}
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = scr_q[4*i +: 4];
      end
    end
    shifted = {adj[DW-2:0], val_q[IN_WIDTH-1]};
    sh_ovf  = carry_q | adj[DW-1];
    val_ext = EW'(val_q);
    hex_ovf = |(val_ext >> DW);
  end

  always_comb begin
    val_d   = val_q;
    scr_d   = scr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          val_d   = value;
          scr_d   = '0;
          carry_d = 1'b0;
          cnt_d   = CW'(IN_WIDTH);
        end
      end
      HEX: begin
        dig_d  = hex_ovf ? sat_hex : val_ext[DW-1:0];
        ovf_d  = hex_ovf;
        done_d = 1'b1;
      end
      SHIFT: begin
        scr_d   = shifted;
        carry_d = sh_ovf;
        val_d   = val_q << 1;
        cnt_d   = cnt_q - CW'(1);
        if (last) begin
          dig_d  = sh_ovf ? sat_dec : shifted;
          ovf_d  = sh_ovf;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    done     = done_q;
    digits   = dig_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_display_value_convert.sv
// Randomised scoreboard bench: two instances (2 and 1 digits) fed the same
// requests, compared against an arithmetic reference model.
module tb_display_value_convert;

  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] value = '0;
  logic          hexMode = 1'b0;
  logic          start = 1'b0;

  logic          busy2, done2, ovf2;
  logic [7:0]    dig2;
  logic          busy1, done1, ovf1;
  logic [3:0]    dig1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int free_cyc = 0;

  typedef struct {
    logic [31:0] dig;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q2[$];
  exp_t q1[$];
  exp_t e2, e1;

  display_value_convert #(.IN_WIDTH(IW), .DIGITS(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .value(value), .hexMode(hexMode),
    .start(start), .busy(busy2), .done(done2), .digits(dig2),
    .overflow(ovf2)
  );

  display_value_convert #(.IN_WIDTH(IW), .DIGITS(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .value(value), .hexMode(hexMode),
    .start(start), .busy(busy1), .done(done1), .digits(dig1),
    .overflow(ovf1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t ref_conv(int v, bit h, int nd, int at);
    exp_t r;
    int base = h ? 16 : 10;
    int lim = 1;
    int d;
    for (int i = 0; i < nd; i++) lim = lim * base;
    r.dig = '0;
    r.cyc = at;
    r.ovf = (v >= lim);
    if (r.ovf) begin
`ifdef DISP_SAT_EN
      for (int i = 0; i < nd; i++) r.dig[4*i +: 4] = 4'(base - 1);
`endif
    end else begin
      d = v;
      for (int i = 0; i < nd; i++) begin
        r.dig[4*i +: 4] = 4'(d % base);
        d = d / base;
      end
    end
    return r;
  endfunction

  task automatic chk(string name, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // called just after a rising edge; one-cycle start pulse
  task automatic issue(int v, bit h);
    int lat = h ? 1 : IW;
    chk("busy2_at_issue", int'(busy2), int'(cyc < free_cyc));
    value = IW'(v);
    hexMode = h;
    start = 1'b1;
    if (cyc >= free_cyc) begin
      q2.push_back(ref_conv(v, h, 2, cyc + 1 + lat));
      q1.push_back(ref_conv(v, h, 1, cyc + 1 + lat));
      free_cyc = cyc + 1 + lat;
    end
    @(posedge clk); #1;
    start = 1'b0;
    value = IW'($urandom);
    hexMode = 1'($urandom);
  endtask

  task automatic wait_free();
    while (cyc < free_cyc) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (done2) begin
      total++;
      if (q2.size() == 0) begin
        bad++;
        $display("FAIL d2_unexpected_done got=%h", dig2);
      end else begin
        e2 = q2.pop_front();
        if (32'(dig2) !== e2.dig || ovf2 !== e2.ovf || cyc !== e2.cyc) begin
          bad++;
          $display("FAIL d2_result got=%h/%b@%0d exp=%h/%b@%0d",
                   dig2, ovf2, cyc, e2.dig[7:0], e2.ovf, e2.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL d1_unexpected_done got=%h", dig1);
      end else begin
        e1 = q1.pop_front();
        if (32'(dig1) !== e1.dig || ovf1 !== e1.ovf || cyc !== e1.cyc) begin
          bad++;
          $display("FAIL d1_result got=%h/%b@%0d exp=%h/%b@%0d",
                   dig1, ovf1, cyc, e1.dig[3:0], e1.ovf, e1.cyc);
        end
      end
    end
  end

  initial begin
    int wait_n;
    step(3);
    chk("rst_busy", int'(busy2 | busy1), 0);
    chk("rst_done", int'(done2 | done1), 0);
    chk("rst_digits", int'({dig2, dig1}), 0);
    chk("rst_ovf", int'(ovf2 | ovf1), 0);
    rst_n = 1'b1;
    step(1);
    free_cyc = cyc;

    issue(255, 0); wait_free();
    issue(0, 0);   wait_free();
    issue(99, 0);  wait_free();
    issue(100, 0); wait_free();
    issue(8'hA7, 1); wait_free();
    issue(8'h1F, 1); wait_free();
    issue(9, 0);   wait_free();
    issue(42, 0);
    step(2);
    issue(77, 0);
    wait_free();
    issue(77, 0);
    wait_free();

    for (int v = 0; v < 256; v++) begin
      for (int h = 0; h < 2; h++) begin
        wait_free();
        step($urandom_range(0, 1));
        issue(v, h[0]);
        if ($urandom_range(0, 3) == 0) issue(int'($urandom_range(0, 255)), 1'($urandom));
      end
    end
    wait_free();
    issue(8'hFF, 1);
    wait_free();

    issue(200, 0);
    step(3);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy2 | busy1), 0);
    chk("arst_done", int'(done2 | done1), 0);
    chk("arst_digits", int'({dig2, dig1}), 0);
    chk("arst_ovf", int'(ovf2 | ovf1), 0);
    q2.delete();
    q1.delete();
    step(3);
    rst_n = 1'b1;
    free_cyc = cyc;
    step(1);
    issue(123, 0); wait_free();
    issue(7, 0);   wait_free();

    wait_n = 0;
    while ((q2.size() != 0 || q1.size() != 0) && wait_n < 40) begin
      @(posedge clk); #1;
      wait_n++;
    end
    chk("queues_drained", q2.size() + q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
